// File: rtl/sprite_cfg_ctrl_if.sv
// SPI byte-stream link between the SPI slave front end and sprite_cfg_ctrl.
// master = SPI slave side (delivers received bytes), slave = command controller.
interface sprite_cfg_ctrl_if;
    logic       cs_active;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       tx_load;

    modport master (output cs_active, rx_valid, rx_data, input tx_data, tx_load);
    modport slave  (input cs_active, rx_valid, rx_data, output tx_data, tx_load);
endinterface

// File: rtl/sprite_cfg_ctrl.sv
// SPI command decoder staging sprite/colour/position writes into shadow registers that commit
// to the active set only on next_frame. Optional STATUS_READBACK_EN adds frame counter + opcode 0x04.
module sprite_cfg_ctrl #(
    parameter int unsigned SPRITE_BITS = 144,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    sprite_cfg_ctrl_if.slave       spi,
    input  logic                   next_frame,
    output logic [SPRITE_BITS-1:0] sprite_data,
    output logic [5:0]             color_bg,
    output logic [5:0]             color_fg,
    output logic [X_W-1:0]         sprite_x,
    output logic [Y_W-1:0]         sprite_y,
    output logic                   cmd_error
);
    localparam int unsigned SpriteLen = SPRITE_BITS / 8;
    localparam int unsigned CntW      = $clog2(SpriteLen + 1);

    localparam logic [7:0] OpNop    = 8'h00;
    localparam logic [7:0] OpSprite = 8'h01;
    localparam logic [7:0] OpColor  = 8'h02;
    localparam logic [7:0] OpPos    = 8'h03;
`ifdef STATUS_READBACK_EN
    localparam logic [7:0] OpStatus = 8'h04;
`endif

    typedef enum logic [1:0] {StIdle, StCmd, StData, StDrop} state_e;

    state_e                 state_q;
    logic [7:0]             op_q;
    logic [CntW-1:0]        cnt_q;
    logic [SPRITE_BITS-1:0] stage_q;
    logic                   apply_q;
    logic                   pending_q;

    logic [SPRITE_BITS-1:0] sh_sprite_q;
    logic [5:0]             sh_bg_q;
    logic [5:0]             sh_fg_q;
    logic [X_W-1:0]         sh_x_q;
    logic [Y_W-1:0]         sh_y_q;

    logic byte_in;
    assign byte_in = spi.cs_active && spi.rx_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= OpNop;
            cnt_q     <= '0;
            stage_q   <= '0;
            apply_q   <= 1'b0;
            cmd_error <= 1'b0;
        end else begin
            apply_q   <= 1'b0;
            cmd_error <= 1'b0;
            if (!spi.cs_active) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: state_q <= StCmd;
                    StCmd: begin
                        if (byte_in) begin
                            op_q <= spi.rx_data;
                            case (spi.rx_data)
                                OpSprite: begin
                                    cnt_q   <= CntW'(SpriteLen);
                                    state_q <= StData;
                                end
                                OpColor: begin
                                    cnt_q   <= CntW'(2);
                                    state_q <= StData;
                                end
                                OpPos: begin
                                    cnt_q   <= CntW'(4);
                                    state_q <= StData;
                                end
                                OpNop: state_q <= StDrop;
`ifdef STATUS_READBACK_EN
                                OpStatus: state_q <= StDrop;
`endif
                                default: begin
                                    state_q   <= StDrop;
                                    cmd_error <= 1'b1;
                                end
                            endcase
                        end
                    end
                    StData: begin
                        if (byte_in) begin
                            stage_q <= {stage_q[SPRITE_BITS-9:0], spi.rx_data};
                            cnt_q   <= cnt_q - CntW'(1);
                            if (cnt_q == CntW'(1)) begin
                                apply_q <= 1'b1;
                                state_q <= StDrop;
                            end
                        end
                    end
                    StDrop:  state_q <= StDrop;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Commit uses the pre-update shadow; a same-cycle shadow update re-arms pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q   <= 1'b0;
            sh_sprite_q <= '0;
            sh_bg_q     <= 6'h00;
            sh_fg_q     <= 6'h3F;
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            sprite_data <= '0;
            color_bg    <= 6'h00;
            color_fg    <= 6'h3F;
            sprite_x    <= '0;
            sprite_y    <= '0;
        end else begin
            if (next_frame && pending_q) begin
                sprite_data <= sh_sprite_q;
                color_bg    <= sh_bg_q;
                color_fg    <= sh_fg_q;
                sprite_x    <= sh_x_q;
                sprite_y    <= sh_y_q;
            end
            if (apply_q) begin
                pending_q <= 1'b1;
                case (op_q)
                    OpSprite: sh_sprite_q <= stage_q;
                    OpColor: begin
                        sh_bg_q <= stage_q[13:8];
                        sh_fg_q <= stage_q[5:0];
                    end
                    OpPos: begin
                        sh_x_q <= stage_q[16 +: X_W];
                        sh_y_q <= stage_q[0 +: Y_W];
                    end
                    default: ;
                endcase
            end else if (next_frame && pending_q) begin
                pending_q <= 1'b0;
            end
        end
    end

`ifdef STATUS_READBACK_EN
    logic [7:0] frame_cnt_q;
    logic [7:0] tx_data_q;
    logic       tx_load_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
        end else begin
            tx_load_q <= 1'b0;
            if (next_frame) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (state_q == StCmd && byte_in && spi.rx_data == OpStatus) begin
                tx_data_q <= {pending_q, frame_cnt_q[6:0]};
                tx_load_q <= 1'b1;
            end
        end
    end

    assign spi.tx_data = tx_data_q;
    assign spi.tx_load = tx_load_q;
`else
    assign spi.tx_data = 8'h00;
    assign spi.tx_load = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_cfg_ctrl.sv
// Randomized self-checking bench for sprite_cfg_ctrl against a transaction-level model.
`timescale 1ns/1ps
module tb_sprite_cfg_ctrl;
    localparam int unsigned SPRITE_BITS = 144;
    localparam int unsigned X_W         = 10;
    localparam int unsigned Y_W         = 10;
    localparam int unsigned SPRITE_LEN  = SPRITE_BITS / 8;

    typedef logic [7:0] bq_t[$];

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   next_frame;
    logic [SPRITE_BITS-1:0] sprite_data;
    logic [5:0]             color_bg;
    logic [5:0]             color_fg;
    logic [X_W-1:0]         sprite_x;
    logic [Y_W-1:0]         sprite_y;
    logic                   cmd_error;

    sprite_cfg_ctrl_if spi ();

    sprite_cfg_ctrl #(
        .SPRITE_BITS(SPRITE_BITS),
        .X_W        (X_W),
        .Y_W        (Y_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .spi        (spi),
        .next_frame (next_frame),
        .sprite_data(sprite_data),
        .color_bg   (color_bg),
        .color_fg   (color_fg),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .cmd_error  (cmd_error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: shadow (m_*) and active (a_*) register sets.
    logic [SPRITE_BITS-1:0] m_sprite, a_sprite;
    logic [5:0]             m_bg, a_bg, m_fg, a_fg;
    logic [X_W-1:0]         m_x, a_x;
    logic [Y_W-1:0]         m_y, a_y;
    logic                   m_pending;
    int                     m_frames;
    int                     exp_err, exp_tx;
    logic [7:0]             exp_txd;

    int         err_seen, tx_seen;
    logic [7:0] last_tx;

    always @(negedge clk) begin
        if (cmd_error === 1'b1) err_seen++;
        if (spi.tx_load === 1'b1) begin
            tx_seen++;
            last_tx = spi.tx_data;
        end
    end

    task automatic check_eq(input string tag, input logic [SPRITE_BITS-1:0] got,
                            input logic [SPRITE_BITS-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_active(input string tag);
        check_eq({tag, ".sprite"}, sprite_data, a_sprite);
        check_eq({tag, ".bg"}, SPRITE_BITS'(color_bg), SPRITE_BITS'(a_bg));
        check_eq({tag, ".fg"}, SPRITE_BITS'(color_fg), SPRITE_BITS'(a_fg));
        check_eq({tag, ".x"}, SPRITE_BITS'(sprite_x), SPRITE_BITS'(a_x));
        check_eq({tag, ".y"}, SPRITE_BITS'(sprite_y), SPRITE_BITS'(a_y));
    endtask

    function automatic int op_len(input logic [7:0] op);
        case (op)
            8'h01:   return SPRITE_LEN;
            8'h02:   return 2;
            8'h03:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit op_known(input logic [7:0] op);
`ifdef STATUS_READBACK_EN
        return op <= 8'h04;
`else
        return op <= 8'h03;
`endif
    endfunction

    task automatic model_reset();
        m_sprite = '0;   a_sprite = '0;
        m_bg = 6'h00;    a_bg = 6'h00;
        m_fg = 6'h3F;    a_fg = 6'h3F;
        m_x = '0;        a_x = '0;
        m_y = '0;        a_y = '0;
        m_pending = 1'b0;
        m_frames = 0;
    endtask

    task automatic model_frame();
        if (m_pending) begin
            a_sprite = m_sprite; a_bg = m_bg; a_fg = m_fg; a_x = m_x; a_y = m_y;
            m_pending = 1'b0;
        end
        m_frames = (m_frames + 1) % 256;
    endtask

    task automatic model_txn(input bq_t b);
        int                     len;
        logic [7:0]             op;
        logic [SPRITE_BITS-1:0] s;
        exp_err = 0;
        exp_tx  = 0;
        exp_txd = '0;
        if (b.size() == 0) return;
        op  = b[0];
        len = op_len(op);
        if (!op_known(op)) exp_err = 1;
`ifdef STATUS_READBACK_EN
        if (op == 8'h04) begin
            exp_tx  = 1;
            exp_txd = {m_pending, 7'(m_frames % 128)};
        end
`endif
        if (len > 0 && b.size() > len) begin
            case (op)
                8'h01: begin
                    s = '0;
                    for (int i = 1; i <= len; i++) s = (s << 8) | SPRITE_BITS'(b[i]);
                    m_sprite = s;
                end
                8'h02: begin
                    m_bg = 6'(b[1] % 64);
                    m_fg = 6'(b[2] % 64);
                end
                default: begin
                    m_x = X_W'((int'(b[1]) * 256 + int'(b[2])) % (1 << X_W));
                    m_y = Y_W'((int'(b[3]) * 256 + int'(b[4])) % (1 << Y_W));
                end
            endcase
            m_pending = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_frame = 1'b0;
        spi.cs_active = 1'b0;
        spi.rx_valid = 1'b0;
        spi.rx_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(negedge clk);
        spi.rx_valid = 1'b1;
        spi.rx_data  = v;
        @(negedge clk);
        spi.rx_valid = 1'b0;
        spi.rx_data  = 8'($urandom);
    endtask

    // collide: next_frame lands on the same edge that the shadow update does.
    task automatic send_txn(input string tag, input bq_t b, input bit collide);
        err_seen = 0;
        tx_seen  = 0;
        @(negedge clk);
        spi.cs_active = 1'b1;
        foreach (b[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(b[i]);
        end
        if (collide) begin
            next_frame = 1'b1;
            @(negedge clk);
            next_frame = 1'b0;
        end
        repeat (3) @(negedge clk);
        spi.cs_active = 1'b0;
        repeat (3) @(negedge clk);
        if (collide) model_frame();
        model_txn(b);
        check_eq({tag, ".err_cnt"}, SPRITE_BITS'(err_seen), SPRITE_BITS'(exp_err));
        check_eq({tag, ".tx_cnt"}, SPRITE_BITS'(tx_seen), SPRITE_BITS'(exp_tx));
        if (exp_tx != 0) check_eq({tag, ".tx_data"}, SPRITE_BITS'(last_tx), SPRITE_BITS'(exp_txd));
        check_active(tag);
    endtask

    task automatic pulse_frame(input string tag);
        @(negedge clk);
        next_frame = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
        @(negedge clk);
        model_frame();
        check_active(tag);
    endtask

    task automatic stray_bytes();
        err_seen = 0;
        repeat (3) send_byte(8'($urandom));
        check_eq("stray.err_cnt", SPRITE_BITS'(err_seen), '0);
        check_active("stray");
    endtask

    initial begin
        bq_t        q;
        logic [7:0] op;
        int         len, n;

        do_reset();
        check_active("reset");
        check_eq("reset.tx_load", SPRITE_BITS'(spi.tx_load), '0);
        check_eq("reset.cmd_error", SPRITE_BITS'(cmd_error), '0);

        q = {8'h02, 8'h15, 8'h2A};
        send_txn("color_nocommit", q, 1'b0);
        pulse_frame("color_commit");
        check_eq("color_bg_15", SPRITE_BITS'(color_bg), SPRITE_BITS'(6'h15));
        check_eq("color_fg_2a", SPRITE_BITS'(color_fg), SPRITE_BITS'(6'h2A));

        q = {8'h03, 8'h01, 8'h40, 8'h00, 8'hF0};
        send_txn("pos", q, 1'b0);
        pulse_frame("pos_commit");
        check_eq("pos_x_140", SPRITE_BITS'(sprite_x), SPRITE_BITS'(10'h140));
        check_eq("pos_y_0f0", SPRITE_BITS'(sprite_y), SPRITE_BITS'(10'h0F0));
        q = {8'h03, 8'hFC, 8'h40, 8'hFF, 8'hF0};
        send_txn("pos_trunc", q, 1'b0);
        pulse_frame("pos_trunc_commit");
        check_eq("pos_trunc_x", SPRITE_BITS'(sprite_x), SPRITE_BITS'(10'h040));

        q = {8'h01};
        repeat (10) q.push_back(8'($urandom));
        send_txn("sprite_short", q, 1'b0);
        pulse_frame("sprite_short_frame");
        q = {8'h01, 8'h80};
        repeat (SPRITE_LEN - 1) q.push_back(8'($urandom));
        send_txn("sprite_full", q, 1'b0);
        pulse_frame("sprite_full_commit");
        check_eq("sprite_msb", SPRITE_BITS'(sprite_data[SPRITE_BITS-1]), SPRITE_BITS'(1'b1));

        q = {8'h7E, 8'h02, 8'h11, 8'h22};
        send_txn("unknown_op", q, 1'b0);
        pulse_frame("unknown_frame");
        q = {8'h00, 8'h02, 8'h33, 8'h0C};
        send_txn("nop_drop", q, 1'b0);

        // Update coinciding with next_frame while nothing was pending: no commit that frame.
        q = {8'h02, 8'h01, 8'h02};
        send_txn("collide_p0", q, 1'b1);
        pulse_frame("collide_p0_next");
        // Same, but with an older write already pending: older shadow commits, new stays pending.
        q = {8'h03, 8'h00, 8'h07, 8'h00, 8'h09};
        send_txn("pend_pos", q, 1'b0);
        q = {8'h02, 8'h2B, 8'h3C};
        send_txn("collide_p1", q, 1'b1);
        pulse_frame("collide_p1_next");

        stray_bytes();

        @(negedge clk);
        spi.cs_active = 1'b1;
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'h55);
        #2 reset = 1'b1;
        #1 model_reset();
        check_active("reset_mid");
        @(negedge clk);
        spi.cs_active = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pulse_frame("after_reset_frame");

        do_reset();
        repeat (5) pulse_frame("status_pre");
        q = {8'h04};
        send_txn("status", q, 1'b0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 9))
                7: pulse_frame("rnd_frame");
                8: stray_bytes();
                9: begin
                    op = 8'($urandom_range(2, 3));
                    q = {op};
                    repeat (op_len(op)) q.push_back(8'($urandom));
                    send_txn("rnd_collide", q, 1'b1);
                end
                default: begin
                    case ($urandom_range(0, 5))
                        0: op = 8'h00;
                        1: op = 8'h01;
                        2: op = 8'h02;
                        3: op = 8'h03;
                        4: op = 8'h04;
                        default: op = 8'($urandom_range(5, 255));
                    endcase
                    len = op_len(op);
                    n = len + $urandom_range(0, 2);
                    if (len > 0 && $urandom_range(0, 3) == 0) n = $urandom_range(0, len - 1);
                    q = {op};
                    repeat (n) q.push_back(8'($urandom));
                    send_txn("rnd_txn", q, 1'b0);
                end
            endcase
        end
        pulse_frame("final_frame");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_cfg_ctrl.md
Name: sprite_cfg_ctrl

Overview:
SPI command controller that sequences configuration writes into the single-sprite renderer.
- Consumes bytes from the SPI byte deserializer and decodes a command byte plus payload.
- Assembles payload into staging/shadow registers.
- Commits shadow to the active registers only on the renderer's next_frame pulse, so the image never tears.
- Sits between the SPI slave and the sprite/SVGA datapath inside top.

Parameters:
SPRITE_BITS, 144, sprite bitmap size in bits (12x12, 1 bpp); must be a multiple of 8.
X_W, 10, sprite X position width.
Y_W, 10, sprite Y position width.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-high
cs_active  input  1  SPI chip select asserted (already synchronized, active-high)
rx_valid  input  1  one-cycle pulse: rx_data holds a complete received byte
rx_data  input  8  received byte, MSB first on the wire
next_frame  input  1  one-cycle pulse from timing generator at frame start
sprite_data  output  SPRITE_BITS  active sprite bitmap
color_bg  output  6  active background colour rrggbb
color_fg  output  6  active sprite colour rrggbb
sprite_x  output  X_W  active sprite X
sprite_y  output  Y_W  active sprite Y
tx_data  output  8  byte to load into the SPI shifter
tx_load  output  1  one-cycle pulse: SPI shifter loads tx_data
cmd_error  output  1  one-cycle pulse on an unknown command byte

Behaviour:
- Reset values (active and shadow):
  - sprite_data = 0
  - color_bg = 6'h00, color_fg = 6'h3F
  - sprite_x = 0, sprite_y = 0
  - tx_data = 0, tx_load = 0, cmd_error = 0
  - pending = 0, FSM in IDLE
- FSM states: IDLE, CMD, DATA, DROP.
  - IDLE -> CMD when cs_active = 1.
  - CMD: first rx_valid byte is the opcode.
    - Known opcode with payload -> DATA; byte counter loads the payload length.
    - NOP -> DROP.
    - Unknown opcode -> DROP, plus cmd_error pulse on the following cycle.
  - DATA: each rx_valid byte shifts into a staging register, MSB-first, big-endian. The counter decrements.
    - On the last byte, staging is copied to the matching shadow field the next cycle, pending is set, and the FSM goes to DROP.
  - DROP: ignores all bytes.
  - Any state -> IDLE whenever cs_active = 0. An incomplete DATA payload is discarded and the shadow is untouched.
- Opcodes:
  - 0x00 NOP, 0 bytes.
  - 0x01 WRITE_SPRITE, SPRITE_BITS/8 bytes (18 by default); first byte lands in sprite_data MSBs.
  - 0x02 WRITE_COLOR, 2 bytes: byte0[5:0] = bg, byte1[5:0] = fg; bits [7:6] are ignored.
  - 0x03 WRITE_POS, 4 bytes: x = {b0,b1} truncated to X_W LSBs; y = {b2,b3} truncated to Y_W LSBs.
  - 0x04 READ_STATUS, 0 bytes, only with the optional feature; otherwise unknown.
- Commit: on a next_frame cycle with pending = 1, every active register loads its shadow and pending clears. Active outputs change on the cycle after next_frame.
  - If a shadow update lands in the same cycle as next_frame: active takes the pre-update shadow only if pending was already 1, and pending remains 1 for the new data.
  - If the update lands and pending was 0, no commit happens that frame.
- Fields not written keep their previous shadow value. Commit copies all fields.
- rx_valid while cs_active = 0 is ignored.
- Reset asserted mid-transfer returns everything to reset values immediately.

Optional Feature:
Macro STATUS_READBACK_EN.
- Defined:
  - 8-bit frame counter increments on every next_frame and wraps 255 -> 0.
  - Opcode 0x04 gives tx_data = {pending, frame_cnt[6:0]} and a tx_load pulse one cycle after the opcode byte; FSM then goes to DROP.
- Undefined:
  - No counter.
  - tx_data = 0 and tx_load = 0 constantly.
  - 0x04 is treated as unknown and pulses cmd_error.

Test Plan:
- Reset, then observe: color_fg = 6'h3F, color_bg = 0, sprite_x = 0, sprite_y = 0, sprite_data = 0, tx_load = 0.
- CS high, bytes 0x02,0x15,0x2A, CS low; no next_frame -> outputs unchanged. Pulse next_frame -> cycle after: color_bg = 6'h15, color_fg = 6'h2A.
- CS high, 0x03,0x01,0x40,0x00,0xF0, then next_frame -> sprite_x = 10'h140, sprite_y = 10'h0F0. Repeat with b0 = 0xFC -> upper bits truncated.
- CS high, 0x01 plus only 10 payload bytes, CS low, next_frame -> sprite_data unchanged and no commit. Full 18-byte transfer with first byte 0x80 -> sprite_data[143] = 1 after next_frame.
- Unknown opcode 0x7E -> exactly one cmd_error pulse; subsequent bytes in the same CS window change nothing.
- STATUS_READBACK_EN defined: 5 next_frame pulses after reset, then opcode 0x04 with pending = 0 -> tx_data = 8'h05 with a one-cycle tx_load. Undefined: same stimulus -> cmd_error pulse and tx_load stays 0.
